// File: rtl/system_counter_csr.sv
// system_counter_csr: per-hart counter/CSR block. Cycle, time, instret and
// NUM_HPM event counters (CNT_WIDTH wide, accessed in XLEN halves), the
// mcountinhibit register and a mtimecmp register driving a timer interrupt.
//
// Request/response: a request is accepted in every cycle i_csr_valid is high
// (there is no ready; the block never stalls). Its response is presented with
// o_rd_valid exactly one cycle later, with o_illegal and o_rdata qualified by
// o_rd_valid. o_rdata carries the CSR value as it was before the request's
// own update, and is 0 for an illegal request.
module system_counter_csr #(
   parameter int XLEN         = 32,
   parameter int CNT_WIDTH    = 64,
   parameter int TIME_CNT_PER = 1024,
   parameter int NUM_HPM      = 4
) (
   input  logic               i_aclk,
   input  logic               i_areset,
   input  logic               i_csr_valid,
   input  logic [1:0]         i_csr_op,
   input  logic [11:0]        i_csr_addr,
   input  logic [XLEN-1:0]    i_csr_wdata,
   input  logic               i_instret,
   input  logic [NUM_HPM-1:0] i_hpm_event,
   output logic               o_rd_valid,
   output logic [XLEN-1:0]    o_rdata,
   output logic               o_illegal,
   output logic               o_timer_irq
);

   // Counter index space: 0 cycle, 1 time, 2 instret, 3+k hpm k.
   localparam int NCNT = 3 + NUM_HPM;
   localparam int PW   = $clog2(TIME_CNT_PER);
   localparam logic [PW-1:0] PRESC_LAST = PW'(TIME_CNT_PER - 1);
   // Writable inhibit bits: 0 (cycle), 2 (instret), 3..NCNT-1 (hpm).
   localparam logic [XLEN-1:0] INH_MASK =
      XLEN'(((64'd1 << NCNT) - 64'd1) & 64'hFFFF_FFFF_FFFF_FFFD);

   typedef enum logic [1:0] {
      OP_READ  = 2'd0,
      OP_WRITE = 2'd1,
      OP_SET   = 2'd2,
      OP_CLEAR = 2'd3
   } csr_op_e;

   logic [CNT_WIDTH-1:0] cnt_q [NCNT];
   logic [CNT_WIDTH-1:0] cnt_d [NCNT];
   logic [PW-1:0]        presc_q, presc_d;
   logic [XLEN-1:0]      inh_q, inh_d;
   logic [CNT_WIDTH-1:0] cmp_q, cmp_d;
   logic                 rd_valid_q, rd_valid_d;
   logic [XLEN-1:0]      rdata_q, rdata_d;
   logic                 illegal_q, illegal_d;
   logic                 irq_q, irq_d;

   csr_op_e         op;
   logic [6:0]      idx;
   logic            hi_half;
   logic            sel_ro, sel_cnt, sel_inh, sel_cmp;
   logic            legal, do_write, tick;
   logic [XLEN-1:0] old_val, new_val;
   logic [NCNT-1:0] inc;

   // Address decode, old-value mux and read-modify-write operand.
   always_comb begin
      op      = csr_op_e'(i_csr_op);
      idx     = i_csr_addr[6:0];
      hi_half = i_csr_addr[7];
      sel_ro  = (i_csr_addr[11:8] == 4'hC) && (idx < 7'(NCNT));
      // 0xB01/0xB81 would be a writable time counter, which does not exist.
      sel_cnt = (i_csr_addr[11:8] == 4'hB) && (idx < 7'(NCNT)) && (idx != 7'd1);
      sel_inh = (i_csr_addr == 12'h320);
      sel_cmp = (i_csr_addr[11:1] == 11'h3E0);
      legal   = (sel_ro && (op == OP_READ)) || sel_cnt || sel_inh || sel_cmp;

      old_val = '0;
      if (sel_ro || sel_cnt) begin
         for (int i = 0; i < NCNT; i++) begin
            if (idx == 7'(i)) begin
               old_val = hi_half ? cnt_q[i][CNT_WIDTH-1:XLEN] : cnt_q[i][XLEN-1:0];
            end
         end
      end else if (sel_inh) begin
         old_val = inh_q;
      end else if (sel_cmp) begin
         old_val = i_csr_addr[0] ? cmp_q[CNT_WIDTH-1:XLEN] : cmp_q[XLEN-1:0];
      end

      case (op)
         OP_WRITE: new_val = i_csr_wdata;
         OP_SET:   new_val = old_val | i_csr_wdata;
         OP_CLEAR: new_val = old_val & ~i_csr_wdata;
         default:  new_val = old_val;
      endcase

      // SET/CLEAR with a zero operand is a pure read.
      do_write = i_csr_valid && legal && !sel_ro &&
                 ((op == OP_WRITE) || ((op != OP_READ) && (i_csr_wdata != '0)));
   end

   // Next state for counters, prescaler, inhibit, mtimecmp and the interrupt.
   always_comb begin
      tick    = (presc_q == PRESC_LAST);
      presc_d = tick ? '0 : presc_q + PW'(1);

      // Increments use the inhibit value held before this cycle's write.
      inc    = '0;
      inc[0] = ~inh_q[0];
      inc[1] = tick;
      inc[2] = i_instret & ~inh_q[2];
      for (int k = 0; k < NUM_HPM; k++) begin
         inc[3+k] = i_hpm_event[k] & ~inh_q[3+k];
      end

      // A half write merges with the un-incremented value, so the increment
      // (and any carry into the other half) is dropped in that cycle.
      for (int i = 0; i < NCNT; i++) begin
         cnt_d[i] = cnt_q[i] + CNT_WIDTH'(inc[i]);
         if (do_write && sel_cnt && (idx == 7'(i))) begin
            cnt_d[i] = hi_half ? {new_val, cnt_q[i][XLEN-1:0]}
                               : {cnt_q[i][CNT_WIDTH-1:XLEN], new_val};
         end
      end

      inh_d = inh_q;
      if (do_write && sel_inh) begin
         inh_d = new_val & INH_MASK;
      end

      cmp_d = cmp_q;
      if (do_write && sel_cmp) begin
         cmp_d = i_csr_addr[0] ? {new_val, cmp_q[XLEN-1:0]}
                               : {cmp_q[CNT_WIDTH-1:XLEN], new_val};
      end

      irq_d = (cnt_d[1] >= cmp_d);
   end

   // Registered response for the request presented this cycle.
   always_comb begin
      rd_valid_d = i_csr_valid;
      illegal_d  = i_csr_valid && !legal;
      rdata_d    = (i_csr_valid && legal) ? old_val : '0;
   end

   // State registers; asynchronous reset drops any pending response.
   always_ff @(posedge i_aclk or posedge i_areset) begin
      if (i_areset) begin
         for (int i = 0; i < NCNT; i++) begin
            cnt_q[i] <= '0;
         end
         presc_q    <= '0;
         inh_q      <= '0;
         cmp_q      <= '1;
         rd_valid_q <= 1'b0;
         rdata_q    <= '0;
         illegal_q  <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         for (int i = 0; i < NCNT; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         presc_q    <= presc_d;
         inh_q      <= inh_d;
         cmp_q      <= cmp_d;
         rd_valid_q <= rd_valid_d;
         rdata_q    <= rdata_d;
         illegal_q  <= illegal_d;
         irq_q      <= irq_d;
      end
   end

   assign o_rd_valid  = rd_valid_q;
   assign o_rdata     = rdata_q;
   assign o_illegal   = illegal_q;
   assign o_timer_irq = irq_q;

endmodule

// File: tb/tb_system_counter_csr.sv
// tb_system_counter_csr: directed scenarios plus random CSR traffic against
// a reference model of the counter/CSR rules. The driver pushes one expected
// entry per cycle; the monitor pops and compares it after each rising edge.
module tb_system_counter_csr;

   localparam int XLEN    = 32;
   localparam int CNT_W   = 64;
   localparam int TCP     = 1024;
   localparam int NUM_HPM = 4;
   localparam int NCNT    = 3 + NUM_HPM;
   localparam int T_INH   = 100;
   localparam int T_CMP   = 101;
   localparam logic [31:0] INH_MASK = 32'h1 | (((32'h1 << (NUM_HPM + 1)) - 32'h1) << 2);

   logic               i_aclk = 1'b0;
   logic               i_areset;
   logic               i_csr_valid;
   logic [1:0]         i_csr_op;
   logic [11:0]        i_csr_addr;
   logic [XLEN-1:0]    i_csr_wdata;
   logic               i_instret;
   logic [NUM_HPM-1:0] i_hpm_event;
   logic               o_rd_valid;
   logic [XLEN-1:0]    o_rdata;
   logic               o_illegal;
   logic               o_timer_irq;

   // Expected entry per cycle: {timer_irq, rd_valid, illegal, rdata}.
   logic [XLEN+2:0] exp_q[$];
   int n_tests = 0;
   int n_fail  = 0;
   bit mon_en  = 1'b0;

   // Reference model state (values visible in the current cycle).
   logic [63:0] m_cycle, m_instret, m_cmp;
   logic [63:0] m_hpm [NUM_HPM];
   longint      m_tcycles;
   logic [31:0] m_inh;

   logic [11:0] addr_tab [0:29] = '{
      12'hC00, 12'hC80, 12'hC01, 12'hC81, 12'hC02, 12'hC82, 12'hC03, 12'hC04,
      12'hC05, 12'hC06, 12'hC83, 12'hC86, 12'hC07, 12'hC87, 12'hB00, 12'hB80,
      12'hB01, 12'hB81, 12'hB02, 12'hB82, 12'hB03, 12'hB06, 12'hB83, 12'hB86,
      12'hB07, 12'h320, 12'h321, 12'h7C0, 12'h7C1, 12'h7C2};

   system_counter_csr #(
      .XLEN(XLEN), .CNT_WIDTH(CNT_W), .TIME_CNT_PER(TCP), .NUM_HPM(NUM_HPM)
   ) dut (
      .i_aclk      (i_aclk),
      .i_areset    (i_areset),
      .i_csr_valid (i_csr_valid),
      .i_csr_op    (i_csr_op),
      .i_csr_addr  (i_csr_addr),
      .i_csr_wdata (i_csr_wdata),
      .i_instret   (i_instret),
      .i_hpm_event (i_hpm_event),
      .o_rd_valid  (o_rd_valid),
      .o_rdata     (o_rdata),
      .o_illegal   (o_illegal),
      .o_timer_irq (o_timer_irq)
   );

   // Clock.
   always #5 i_aclk = ~i_aclk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] m_time();
      return 64'(m_tcycles / TCP);
   endfunction

   function automatic logic [63:0] m_get(input int tgt);
      case (tgt)
         0:       return m_cycle;
         1:       return m_time();
         2:       return m_instret;
         T_INH:   return {32'h0, m_inh};
         T_CMP:   return m_cmp;
         default: return m_hpm[tgt-3];
      endcase
   endfunction

   task automatic m_set(input int tgt, input logic [63:0] v);
      case (tgt)
         0:       m_cycle = v;
         2:       m_instret = v;
         default: m_hpm[tgt-3] = v;
      endcase
   endtask

   // Address map lookup from the documented CSR numbers.
   task automatic m_decode(input logic [1:0] op, input logic [11:0] addr,
                           output bit ill, output bit ro, output int tgt, output bit hi);
      ill = 1'b1; ro = 1'b0; tgt = 0; hi = 1'b0;
      for (int i = 0; i < NCNT; i++) begin
         if (addr == 12'hC00 + 12'(i)) begin ill = (op != 2'd0); ro = 1'b1; tgt = i; hi = 1'b0; end
         if (addr == 12'hC80 + 12'(i)) begin ill = (op != 2'd0); ro = 1'b1; tgt = i; hi = 1'b1; end
         if (i != 1 && addr == 12'hB00 + 12'(i)) begin ill = 1'b0; tgt = i; hi = 1'b0; end
         if (i != 1 && addr == 12'hB80 + 12'(i)) begin ill = 1'b0; tgt = i; hi = 1'b1; end
      end
      if (addr == 12'h320) begin ill = 1'b0; tgt = T_INH; end
      if (addr == 12'h7C0) begin ill = 1'b0; tgt = T_CMP; hi = 1'b0; end
      if (addr == 12'h7C1) begin ill = 1'b0; tgt = T_CMP; hi = 1'b1; end
   endtask

   task automatic m_reset();
      m_cycle = '0; m_instret = '0; m_tcycles = 0; m_inh = '0; m_cmp = '1;
      for (int k = 0; k < NUM_HPM; k++) m_hpm[k] = '0;
   endtask

   // Driver: apply one cycle of stimulus, record the expectation, advance the model.
   task automatic step(input bit v, input logic [1:0] op, input logic [11:0] addr,
                       input logic [31:0] wd, input bit ir, input logic [NUM_HPM-1:0] ev);
      bit ill, ro, hi, wr;
      int tgt;
      logic [63:0] oldv;
      logic [31:0] rv, nv;
      i_csr_valid = v; i_csr_op = op; i_csr_addr = addr; i_csr_wdata = wd;
      i_instret = ir; i_hpm_event = ev;
      m_decode(op, addr, ill, ro, tgt, hi);
      oldv = ill ? 64'h0 : m_get(tgt);
      rv   = hi ? oldv[63:32] : oldv[31:0];
      if (ill) rv = '0;
      case (op)
         2'd1:    nv = wd;
         2'd2:    nv = rv | wd;
         2'd3:    nv = rv & ~wd;
         default: nv = rv;
      endcase
      wr = v && !ill && !ro && (op == 2'd1 || (op != 2'd0 && wd != 0));
      // Counting uses the inhibit bits as they stand before any write.
      if (!m_inh[0]) m_cycle++;
      if (ir && !m_inh[2]) m_instret++;
      for (int k = 0; k < NUM_HPM; k++) if (ev[k] && !m_inh[3+k]) m_hpm[k]++;
      m_tcycles++;
      if (wr) begin
         if (tgt == T_INH) m_inh = nv & INH_MASK;
         else if (tgt == T_CMP) m_cmp = hi ? {nv, m_cmp[31:0]} : {m_cmp[63:32], nv};
         else m_set(tgt, hi ? {nv, oldv[31:0]} : {oldv[63:32], nv});
      end
      exp_q.push_back({(m_time() >= m_cmp), v, v && ill, v ? rv : 32'h0});
      @(negedge i_aclk);
   endtask

   task automatic idle();
      step(1'b0, 2'd0, 12'h0, 32'h0, 1'b0, '0);
   endtask

   task automatic rd(input logic [11:0] a);
      step(1'b1, 2'd0, a, 32'h0, 1'b0, '0);
   endtask

   task automatic wr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
      step(1'b1, op, a, d, 1'b0, '0);
   endtask

   // Reset: async assert, check outputs immediately, drop expectations, release on a falling edge.
   task automatic do_reset();
      mon_en = 1'b0;
      i_areset = 1'b1;
      #1;
      check("rst_rd_valid", o_rd_valid, 0);
      check("rst_rdata", o_rdata, 0);
      check("rst_illegal", o_illegal, 0);
      check("rst_timer_irq", o_timer_irq, 0);
      i_csr_valid = 1'b0; i_csr_op = '0; i_csr_addr = '0; i_csr_wdata = '0;
      i_instret = 1'b0; i_hpm_event = '0;
      exp_q.delete();
      m_reset();
      repeat (2) @(negedge i_aclk);
      i_areset = 1'b0;
      mon_en = 1'b1;
   endtask

   // Monitor / scoreboard: compare every cycle's outputs with the queued expectation.
   initial begin
      logic [XLEN+2:0] e;
      forever begin
         @(posedge i_aclk);
         #1;
         if (mon_en) begin
            if (exp_q.size() == 0) begin
               check("scoreboard_underflow", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("timer_irq", o_timer_irq, e[XLEN+2]);
               check("rd_valid", o_rd_valid, e[XLEN+1]);
               if (e[XLEN+1]) begin
                  check("rd_illegal", o_illegal, e[XLEN]);
                  check("rd_data", o_rdata, e[XLEN-1:0]);
               end
            end
         end
      end
   end

   // Stimulus.
   initial begin
      do_reset();

      // Cycle and time counting from reset release.
      repeat (10) idle();
      rd(12'hC00);
      repeat (2047 - 11) idle();
      rd(12'hC01);
      rd(12'hC81);

      // Full 64-bit wrap of mcycle.
      wr(2'd1, 12'hB00, 32'hFFFF_FFFF);
      wr(2'd1, 12'hB80, 32'hFFFF_FFFF);
      rd(12'hC00);
      rd(12'hC80);
      rd(12'hC00);

      // instret with inhibit, then an event counter.
      repeat (5) step(1'b0, 2'd0, 12'h0, 32'h0, 1'b1, '0);
      wr(2'd2, 12'h320, 32'h4);
      repeat (3) step(1'b0, 2'd0, 12'h0, 32'h0, 1'b1, '0);
      rd(12'hC02);
      for (int i = 0; i < 7; i++) begin
         step(1'b0, 2'd0, 12'h0, 32'h0, 1'b0, 4'b0010);
         idle();
      end
      rd(12'hC04);
      wr(2'd3, 12'h320, 32'h4);
      // Write wins over a same-cycle increment.
      step(1'b1, 2'd1, 12'hB02, 32'h100, 1'b1, '0);
      rd(12'hC02);

      // Illegal requests leave state untouched.
      wr(2'd1, 12'hC00, 32'h5);
      rd(12'hC09);
      rd(12'h123);
      wr(2'd2, 12'hC01, 32'h1);
      rd(12'hB01);
      rd(12'hC00);

      // mcountinhibit writable bits.
      wr(2'd2, 12'h320, 32'hFFFF_FFFF);
      rd(12'h320);
      wr(2'd3, 12'h320, 32'h1);
      rd(12'h320);
      wr(2'd3, 12'h320, 32'hFFFF_FFFF);
      wr(2'd2, 12'h320, 32'h0);
      rd(12'h320);

      // Reset with a request in flight.
      i_csr_valid = 1'b1; i_csr_op = 2'd0; i_csr_addr = 12'hC00;
      #2;
      do_reset();
      rd(12'hC00);

      // Timer interrupt against mtimecmp = 3.
      wr(2'd1, 12'h7C1, 32'h0);
      wr(2'd1, 12'h7C0, 32'h3);
      repeat (3 * TCP + 3) idle();
      rd(12'hC01);
      wr(2'd1, 12'h7C0, 32'hFFFF_FFFF);
      repeat (3) idle();
      rd(12'h7C0);
      rd(12'h7C1);

      // Random traffic.
      for (int n = 0; n < 3000; n++) begin
         bit v;
         logic [1:0] op;
         logic [11:0] a;
         logic [31:0] d;
         v  = ($urandom_range(0, 3) != 0);
         op = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 9) == 0) a = 12'($urandom());
         else a = addr_tab[$urandom_range(0, 29)];
         case ($urandom_range(0, 3))
            0:       d = '0;
            1:       d = '1;
            default: d = $urandom();
         endcase
         step(v, op, a, d, 1'($urandom_range(0, 1)), NUM_HPM'($urandom()));
      end
      idle();

      check("scoreboard_drained", exp_q.size(), 0);
      mon_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
